// File: rtl/relm_uart_ch.sv
// relm_uart_ch: UART channel for the ReLM push/pop I/O fabric.
//
// One push channel feeds a TX FIFO and serialiser; one pop channel returns a
// registered status word carrying the RX FIFO head, FIFO levels and sticky
// error flags. Frame format: start, 8 data bits LSB first, optional parity,
// one or two stop bits, each bit lasting DIV clocks.
//
// Ports:
//   clk         system clock
//   rst_n_in    asynchronous active-low reset
//   uart_in     serial RX line (asynchronous, idle high)
//   uart_out    serial TX line (idle high)
//   push_d      [WD] write strobe, [7:0] byte to transmit
//   push_retry  TX FIFO full; a strobed write this cycle is not accepted
//   pop_d       [WD-2] consume RX head, [WD-3] clear error flags
//   pop_q       [WD-1] tx_not_full, [WD-2] rx_valid, [WD-3] parity_err,
//               [WD-4] frame_err, [WD-5] overrun, [7:0] RX head byte
module relm_uart_ch #(
  parameter int unsigned WD     = 32,
  parameter int unsigned DIV    = 434,
  parameter int unsigned WAF    = 4,
  parameter int unsigned PARITY = 0,
  parameter int unsigned STOP2  = 0
) (
  input  logic        clk,
  input  logic        rst_n_in,
  input  logic        uart_in,
  output logic        uart_out,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q
);

  localparam int unsigned Depth    = 2 ** WAF;
  localparam logic [15:0] BitCnt   = 16'(DIV - 1);
  localparam logic [15:0] HalfCnt  = 16'(DIV / 2 - 1);
  localparam logic        ParEn    = (PARITY != 0);
  localparam logic        ParOdd   = (PARITY == 1);
  localparam logic        Stop2    = (STOP2 != 0);
  localparam logic [WAF:0] FullXor = {1'b1, {WAF{1'b0}}};
  localparam logic [WD:0] StatusRst = {2'b01, {(WD - 1){1'b0}}};

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;

  // Only the strobe, byte and the two control bits carry meaning.
  logic unused_bits;
  assign unused_bits = ^{push_d[WD-1:8], pop_d};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]   tx_mem_q [Depth];
  logic [WAF:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic         tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]   tx_head;

  assign tx_full    = (tx_wr_ptr_q ^ tx_rd_ptr_q) == FullXor;
  assign tx_empty   = tx_wr_ptr_q == tx_rd_ptr_q;
  assign tx_push    = push_d[WD] & ~tx_full;
  assign push_retry = tx_full;
  assign tx_head    = tx_mem_q[tx_rd_ptr_q[WAF-1:0]];

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + {{WAF{1'b0}}, tx_push};
    tx_rd_ptr_d = tx_rd_ptr_q + {{WAF{1'b0}}, tx_pop};
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q[WAF-1:0]] <= push_d[7:0];
  end

  // ---------------------------------------------------------------------------
  // TX serialiser. uart_out is registered from the current state, so the line
  // follows the state by one clock; each bit still lasts exactly DIV clocks.
  // ---------------------------------------------------------------------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_stop_q, tx_stop_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        uart_out_q, uart_out_d;
  logic        tx_expire;

  assign tx_expire = tx_cnt_q == 16'd0;
  assign uart_out  = uart_out_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_byte_d  = tx_byte_q;
    tx_pop     = 1'b0;
    uart_out_d = 1'b1;
    if (tx_state_q != TxIdle && !tx_expire) tx_cnt_d = tx_cnt_q - 16'd1;
    unique case (tx_state_q)
      TxIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_head;
          tx_cnt_d   = BitCnt;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        uart_out_d = 1'b0;
        if (tx_expire) begin
          tx_cnt_d   = BitCnt;
          tx_bit_d   = 3'd0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        uart_out_d = tx_byte_q[tx_bit_q];
        if (tx_expire) begin
          tx_cnt_d  = BitCnt;
          tx_bit_d  = tx_bit_q + 3'd1;
          tx_stop_d = 1'b0;
          if (tx_bit_q == 3'd7) tx_state_d = ParEn ? TxParity : TxStop;
        end
      end
      TxParity: begin
        uart_out_d = ^tx_byte_q ^ ParOdd;
        if (tx_expire) begin
          tx_cnt_d   = BitCnt;
          tx_state_d = TxStop;
        end
      end
      TxStop: begin
        uart_out_d = 1'b1;
        if (tx_expire) begin
          if (Stop2 && !tx_stop_q) begin
            tx_stop_d = 1'b1;
            tx_cnt_d  = BitCnt;
          end else if (!tx_empty) begin
            // Back-to-back frame: no idle gap after the last stop bit.
            tx_pop     = 1'b1;
            tx_byte_d  = tx_head;
            tx_cnt_d   = BitCnt;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser and deserialiser
  // ---------------------------------------------------------------------------
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_expire, rx_done, perr_set, ferr_set;

  assign rx_expire = rx_cnt_q == 16'd0;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    if (rx_state_q != RxIdle && rx_state_q != RxBreak && !rx_expire) begin
      rx_cnt_d = rx_cnt_q - 16'd1;
    end
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          // Half a bit to land on the middle of the start bit.
          rx_cnt_d   = HalfCnt;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_expire) begin
          if (rx_sync_q) begin
            rx_state_d = RxIdle;
          end else begin
            rx_cnt_d   = BitCnt;
            rx_bit_d   = 3'd0;
            rx_state_d = RxData;
          end
        end
      end
      RxData: begin
        if (rx_expire) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BitCnt;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = ParEn ? RxParity : RxStop;
        end
      end
      RxParity: begin
        if (rx_expire) begin
          perr_set   = rx_sync_q != (^rx_shift_q ^ ParOdd);
          rx_cnt_d   = BitCnt;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_expire) begin
          if (rx_sync_q) begin
            rx_done    = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            ferr_set   = 1'b1;
            rx_state_d = RxBreak;
          end
        end
      end
      RxBreak: begin
        // Hold off until the line returns high so a break is one error.
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FIFO and error flags
  // ---------------------------------------------------------------------------
  logic [7:0]   rx_mem_q [Depth];
  logic [WAF:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic         rx_full, rx_empty, rx_write, rx_pop, ovr_set, err_clr;
  logic [7:0]   rx_head;
  logic         perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  assign rx_full  = (rx_wr_ptr_q ^ rx_rd_ptr_q) == FullXor;
  assign rx_empty = rx_wr_ptr_q == rx_rd_ptr_q;
  assign rx_head  = rx_mem_q[rx_rd_ptr_q[WAF-1:0]];
  assign rx_pop   = pop_d[WD-2] & ~rx_empty;
  // A read in the same cycle frees a slot, so a full FIFO can still take it.
  assign rx_write = rx_done & (~rx_full | rx_pop);
  assign ovr_set  = rx_done & rx_full & ~rx_pop;
  assign err_clr  = pop_d[WD-3];

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + {{WAF{1'b0}}, rx_write};
    rx_rd_ptr_d = rx_rd_ptr_q + {{WAF{1'b0}}, rx_pop};
    // A new error in the same cycle as a clear stays set.
    perr_d      = perr_set | (perr_q & ~err_clr);
    ferr_d      = ferr_set | (ferr_q & ~err_clr);
    ovr_d       = ovr_set | (ovr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rx_write) rx_mem_q[rx_wr_ptr_q[WAF-1:0]] <= rx_shift_q;
  end

  // ---------------------------------------------------------------------------
  // Status word, built from registered state
  // ---------------------------------------------------------------------------
  logic [WD:0] status_q, status_d;

  assign pop_q = status_q;

  always_comb begin
    status_d        = '0;
    status_d[WD-1]  = ~tx_full;
    status_d[WD-2]  = ~rx_empty;
    status_d[WD-3]  = perr_q;
    status_d[WD-4]  = ferr_q;
    status_d[WD-5]  = ovr_q;
    status_d[7:0]   = rx_empty ? 8'h00 : rx_head;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_stop_q   <= 1'b0;
      tx_byte_q   <= '0;
      uart_out_q  <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      status_q    <= StatusRst;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_stop_q   <= tx_stop_d;
      tx_byte_q   <= tx_byte_d;
      uart_out_q  <= uart_out_d;
      rx_meta_q   <= uart_in;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      status_q    <= status_d;
    end
  end

endmodule

// File: tb/tb_relm_uart_ch.sv
// tb_relm_uart_ch: directed bench for relm_uart_ch.
// dut_a: DIV=4, WAF=2, no parity (TX timing, FIFO full, reset).
// dut_b: DIV=8, WAF=2, even parity (loopback, RX errors, overrun, glitch).
module tb_relm_uart_ch;

  localparam int unsigned WD = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [WD:0] push_a, pop_a, popq_a, push_b, pop_b, popq_b;
  logic        uart_out_a, uart_out_b, retry_a, retry_b;
  logic        line_a, line_b, loop_b, rx_b;
  logic [WD:0] st_rst, cons, clr;
  logic [7:0]  fr [5];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign rx_b = loop_b ? uart_out_b : line_b;

  relm_uart_ch #(.WD(WD), .DIV(4), .WAF(2), .PARITY(0), .STOP2(0)) dut_a (
    .clk        (clk),
    .rst_n_in   (rst_n),
    .uart_in    (line_a),
    .uart_out   (uart_out_a),
    .push_d     (push_a),
    .push_retry (retry_a),
    .pop_d      (pop_a),
    .pop_q      (popq_a)
  );

  relm_uart_ch #(.WD(WD), .DIV(8), .WAF(2), .PARITY(2), .STOP2(0)) dut_b (
    .clk        (clk),
    .rst_n_in   (rst_n),
    .uart_in    (rx_b),
    .uart_out   (uart_out_b),
    .push_d     (push_b),
    .push_retry (retry_b),
    .pop_d      (pop_b),
    .pop_q      (popq_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [WD:0] obs, input logic [WD:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WD:0] mkpush(input logic [7:0] b);
    return {1'b1, {(WD - 8){1'b0}}, b};
  endfunction

  // Expected line level for bit slot k of a frame: 0 start, 1..8 data,
  // 9 parity when enabled, stop otherwise.
  function automatic logic exp_bit(input logic [7:0] b, input int par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par != 0 && k == 9) return (par == 1) ? ~(^b) : ^b;
    return 1'b1;
  endfunction

  // Checks n frames from fr[] cycle by cycle, starting e cycles after the
  // first start bit appeared.
  task automatic check_tx(input int sel, input int n, input int div, input int par,
                          input int start_e);
    int flen;
    flen = div * ((par != 0) ? 11 : 10);
    for (int e = start_e; e < n * flen; e++) begin
      check1($sformatf("tx f%0d c%0d", e / flen, e % flen),
             (sel != 0) ? uart_out_b : uart_out_a,
             exp_bit(fr[e / flen], par, (e % flen) / div));
      tick();
    end
  endtask

  // Drives one frame on line_b at DIV=8 with explicit parity and stop levels.
  task automatic send_b(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    line_b = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      line_b = b[i];
      repeat (8) tick();
    end
    line_b = par_bit;
    repeat (8) tick();
    line_b = stop_bit;
    repeat (8) tick();
    if (!stop_bit) repeat (16) tick();
    line_b = 1'b1;
    repeat (6) tick();
  endtask

  task automatic consume_b();
    pop_b = cons;
    tick();
    pop_b = '0;
    tick();
  endtask

  task automatic wait_rx_b();
    for (int i = 0; i < 60; i++) begin
      if (popq_b[WD-2]) break;
      tick();
    end
    check1("rx wait", popq_b[WD-2], 1'b1);
  endtask

  initial begin
    st_rst = '0; st_rst[WD-1] = 1'b1;
    cons = '0;   cons[WD] = 1'b1; cons[WD-2] = 1'b1;
    clr = '0;    clr[WD] = 1'b1;  clr[WD-3] = 1'b1;
    push_a = '0; push_b = '0; pop_a = '0; pop_b = '0;
    line_a = 1'b1; line_b = 1'b1; loop_b = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check1("rst uart_out_a", uart_out_a, 1'b1);
    check1("rst retry_a", retry_a, 1'b0);
    checkw("rst pop_q_a", popq_a, st_rst);
    checkw("rst pop_q_b", popq_b, st_rst);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkw("idle pop_q_a", popq_a, st_rst);
    check1("idle uart_out_b", uart_out_b, 1'b1);

    // Single byte, start bit two edges after the write.
    fr[0] = 8'hA5;
    push_a = mkpush(8'hA5);
    tick();
    push_a = '0;
    check1("a5 edge0", uart_out_a, 1'b1);
    check1("a5 retry", retry_a, 1'b0);
    tick();
    check1("a5 edge1", uart_out_a, 1'b1);
    tick();
    check_tx(0, 1, 4, 0, 0);
    check1("a5 after", uart_out_a, 1'b1);
    check1("a5 retry after", retry_a, 1'b0);
    repeat (4) tick();

    // Five back-to-back writes: one goes to the shifter, four fill the FIFO.
    fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h3C; fr[3] = 8'h80; fr[4] = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      push_a = mkpush(fr[i]);
      tick();
      if (i == 1) check1("burst start pending", uart_out_a, 1'b1);
    end
    check1("burst full retry", retry_a, 1'b1);
    push_a = mkpush(8'h00);
    tick();
    push_a = '0;
    check1("burst not_full", popq_a[WD-1], 1'b0);
    check_tx(0, 5, 4, 0, 3);
    check1("burst retry clear", retry_a, 1'b0);
    repeat (8) tick();
    check1("burst dropped 6th", uart_out_a, 1'b1);

    // Loopback with even parity, parity bit 0 then 1.
    loop_b = 1'b1;
    fr[0] = 8'h3C;
    push_b = mkpush(8'h3C);
    tick();
    push_b = '0;
    repeat (2) tick();
    check_tx(1, 1, 8, 2, 0);
    wait_rx_b();
    check8("lb 3c byte", popq_b[7:0], 8'h3C);
    check1("lb 3c perr", popq_b[WD-3], 1'b0);
    check1("lb 3c ferr", popq_b[WD-4], 1'b0);
    pop_b = cons;
    tick();
    pop_b = '0;
    check1("lb consume same", popq_b[WD-2], 1'b1);
    tick();
    check1("lb consume next", popq_b[WD-2], 1'b0);

    fr[0] = 8'h07;
    push_b = mkpush(8'h07);
    tick();
    push_b = '0;
    repeat (2) tick();
    check_tx(1, 1, 8, 2, 0);
    wait_rx_b();
    check8("lb 07 byte", popq_b[7:0], 8'h07);
    check1("lb 07 perr", popq_b[WD-3], 1'b0);
    consume_b();
    loop_b = 1'b0;
    line_b = 1'b1;
    repeat (4) tick();

    // Framing error with a break, then good bytes; flags stay sticky.
    send_b(8'hA5, 1'b0, 1'b0);
    check1("fe ferr", popq_b[WD-4], 1'b1);
    check1("fe valid", popq_b[WD-2], 1'b0);
    check1("fe perr", popq_b[WD-3], 1'b0);
    send_b(8'h55, 1'b0, 1'b1);
    check1("55 valid", popq_b[WD-2], 1'b1);
    check8("55 byte", popq_b[7:0], 8'h55);
    check1("55 ferr sticky", popq_b[WD-4], 1'b1);
    send_b(8'h01, 1'b0, 1'b1);
    check1("01 perr", popq_b[WD-3], 1'b1);
    check8("01 head still 55", popq_b[7:0], 8'h55);
    pop_b = cons | clr;
    tick();
    pop_b = '0;
    tick();
    check1("clr ferr", popq_b[WD-4], 1'b0);
    check1("clr perr", popq_b[WD-3], 1'b0);
    check8("01 head", popq_b[7:0], 8'h01);
    consume_b();
    check1("drained", popq_b[WD-2], 1'b0);

    // Overrun: five bytes into a four-deep FIFO.
    fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33; fr[3] = 8'h44; fr[4] = 8'h66;
    for (int i = 0; i < 5; i++) send_b(fr[i], ^fr[i], 1'b1);
    check1("ovr flag", popq_b[WD-5], 1'b1);
    check1("ovr perr", popq_b[WD-3], 1'b0);
    for (int i = 0; i < 4; i++) begin
      check1($sformatf("ovr valid %0d", i), popq_b[WD-2], 1'b1);
      check8($sformatf("ovr byte %0d", i), popq_b[7:0], fr[i]);
      consume_b();
    end
    check1("ovr empty", popq_b[WD-2], 1'b0);
    check1("ovr sticky", popq_b[WD-5], 1'b1);
    pop_b = clr;
    tick();
    pop_b = '0;
    tick();
    check1("ovr cleared", popq_b[WD-5], 1'b0);

    // One-clock glitch while idle.
    line_b = 1'b0;
    tick();
    line_b = 1'b1;
    repeat (30) tick();
    check1("glitch valid", popq_b[WD-2], 1'b0);
    checkw("glitch status", popq_b, st_rst);

    // Reset in the middle of a TX frame.
    push_a = mkpush(8'h00);
    tick();
    push_a = '0;
    repeat (12) tick();
    check1("mid frame low", uart_out_a, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check1("async uart_out", uart_out_a, 1'b1);
    check1("async not_full", popq_a[WD-1], 1'b1);
    checkw("async pop_q", popq_a, st_rst);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) tick();
    check1("post rst idle", uart_out_a, 1'b1);
    checkw("post rst pop_q", popq_a, st_rst);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
